iter_ctrl: RTL and testbench
============================

Name: iter_ctrl

Overview:
- Control FSM that drives an iteration counter's initCount/enCount and consumes its nEqual terminal flag (asserted when count == N-2).
- Sequences exactly N datapath steps (load, N step pulses, done) for the shift/add datapaths in the final design.
- Adds start/busy/done handshake, illegal-N rejection, abort, and a watchdog for a missing nEqual.

Parameters:
- CW, 4, width of iteration count N and of the internal watchdog counter.
- WDOG_MAX, 15, maximum RUN cycles without nEqual before abort with error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- abort  input  1  synchronous cancel; highest priority after rst.
- nIn  input  CW  iteration count N; latched on accepted start.
- nEqual  input  1  terminal flag from the iteration counter (count == N-2).
- initCount  output  1  clear iteration counter.
- enCount  output  1  increment iteration counter.
- ldReg  output  1  load datapath operands.
- stepEn  output  1  perform one datapath iteration.
- busy  output  1  high from the INIT cycle through the cycle before DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky status: last run ended in error; cleared on next accepted start.
- nLat  output  CW  latched N; drives the counter's N input.

Behaviour:
- Reset: state IDLE, nLat=0, watchdog=0, err=0. All outputs are 0.
- Control outputs (initCount, enCount, ldReg, stepEn, busy, done) are Moore-decoded from the state register only. No combinational path from inputs to outputs.
- IDLE:
  - All control outputs 0.
  - start=1 with nIn>=2: latch nLat=nIn, clear err, go to INIT.
  - start=1 with nIn<2: latch nLat, set err=1, go to DONE.
- INIT (1 cycle): initCount=1, ldReg=1, busy=1. Clears watchdog. Always goes to RUN.
- RUN:
  - stepEn=1, enCount=1, busy=1. Watchdog increments each cycle.
  - nEqual=1 sampled this cycle: go to LAST. That RUN cycle is step N-1.
  - Otherwise, watchdog == WDOG_MAX-1: set err=1, go to DONE.
  - Otherwise stay in RUN.
- LAST (1 cycle): stepEn=1, enCount=0, busy=1. Performs step N. Goes to DONE.
- DONE (1 cycle): done=1, busy=0. Goes to IDLE. A start asserted during DONE is ignored; start must be high in IDLE to be accepted.
- Latency for legal N:
  - start accepted at edge k: INIT at cycle k+1, RUN at k+2 .. k+N.
  - LAST at k+N+1, done at k+N+2.
  - stepEn high for exactly N cycles; enCount high for N-1 cycles.
- N=2: nEqual is already true in the first RUN cycle (count 0). Sequence is RUN x1, LAST, DONE; 2 steps total.
- N=15 (max for CW=4): 14 RUN cycles; the watchdog (WDOG_MAX=15) does not fire.
- abort=1 in any state other than IDLE: next state IDLE. done is not pulsed, err is unchanged, nLat is held. Abort in IDLE has no effect.
- abort and start both high in IDLE: start proceeds.
- start while busy: ignored; nLat is not relatched.
- nEqual is ignored outside RUN.
- Async rst mid-run: immediately returns to IDLE with all outputs 0. No done is pulsed.

Test Plan:
- Reset, then start with nIn=4, nEqual modelled by a counter at nLat-2 -> INIT 1 cycle, stepEn high 4 cycles, enCount high 3 cycles, done pulse 6 cycles after the start edge, err=0.
- start with nIn=2 -> single RUN cycle then LAST, stepEn high 2 cycles, done at start+4.
- start with nIn=1 and again with nIn=0 -> no INIT/stepEn, done next cycle with err=1. Then start with nIn=3 -> err clears on the INIT cycle.
- nEqual held at 0 with nIn=5 -> 15 RUN cycles, then done with err=1, busy falls.
- Abort in the 2nd RUN cycle with nIn=6 -> IDLE next cycle, no done, stepEn/enCount 0. Separately, rst pulse in LAST -> all outputs 0 immediately.
- start re-asserted during RUN and during DONE with nIn=9 -> nLat keeps its original value, no second INIT until start is high in IDLE.

Source files
------------

// File: rtl/iter_ctrl.sv
// iter_ctrl: start/busy/done sequencer for an N-step iterative datapath,
// driving the iteration counter and watching its nEqual terminal flag.
module iter_ctrl #(
    parameter int CW       = 4,
    parameter int WDOG_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] nIn,
    input  logic          nEqual,
    output logic          initCount,
    output logic          enCount,
    output logic          ldReg,
    output logic          stepEn,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] nLat
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, LAST, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_wdog;
    logic          w_legal, w_wdog_exp, w_set_err;

    assign w_legal    = nIn >= CW'(2);
    assign w_wdog_exp = r_wdog == CW'(WDOG_MAX - 1);

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? (w_legal ? INIT : DONE) : IDLE;
            INIT:    w_next = RUN;
            RUN: begin
                w_next    = nEqual ? LAST : (w_wdog_exp ? DONE : RUN);
                w_set_err = !nEqual && w_wdog_exp;
            end
            LAST:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // abort outranks everything except an IDLE start, and leaves err alone
        if (abort && r_state != IDLE) begin
            w_next    = IDLE;
            w_set_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wdog  <= '0;
            nLat    <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wdog  <= r_state == INIT ? '0 : (r_state == RUN ? r_wdog + 1'b1 : r_wdog);
            if (r_state == IDLE && start) begin
                nLat <= nIn;
                err  <= !w_legal;
            end else if (w_set_err) begin
                err <= 1'b1;
            end
        end
    end

    assign initCount = r_state == INIT;
    assign ldReg     = r_state == INIT;
    assign enCount   = r_state == RUN;
    assign stepEn    = r_state == RUN || r_state == LAST;
    assign busy      = r_state == INIT || r_state == RUN || r_state == LAST;
    assign done      = r_state == DONE;
endmodule

// File: tb/tb_iter_ctrl.sv
// tb_iter_ctrl: randomized and directed bench for iter_ctrl against a
// run-level model that expands each accepted start into its cycle schedule.
module tb_iter_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, abort, nEqual;
    logic [3:0] nIn;
    logic       initCount, enCount, ldReg, stepEn, busy, done, err;
    logic [3:0] nLat;

    iter_ctrl #(.CW(4), .WDOG_MAX(15)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .nIn(nIn), .nEqual(nEqual),
        .initCount(initCount), .enCount(enCount), .ldReg(ldReg), .stepEn(stepEn),
        .busy(busy), .done(done), .err(err), .nLat(nLat)
    );

    always #5 clk = ~clk;

    // iteration counter the controller drives; noise pokes nEqual outside RUN
    logic [3:0] cnt, w_term;
    logic       noise = 1'b0, neq_off = 1'b0;
    always @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (initCount) cnt <= '0;
        else if (enCount) cnt <= cnt + 4'd1;
    assign w_term = nLat - 4'd2;
    assign nEqual = !neq_off && ((cnt == w_term) || (noise && !enCount));

    // {initCount, enCount, ldReg, stepEn, busy, done, err}
    localparam logic [6:0] V_INIT = 7'b1010100;
    localparam logic [6:0] V_RUN  = 7'b0101100;
    localparam logic [6:0] V_LAST = 7'b0001100;
    localparam logic [6:0] V_DONE = 7'b0000010;

    logic [6:0] obs;
    assign obs = {initCount, enCount, ldReg, stepEn, busy, done, err};

    logic [6:0] exp_q[$];
    logic [6:0] m_cur = '0;
    logic [3:0] m_nlat = '0;
    int vectors = 0, miscompares = 0;

    task automatic tick();
        logic idle;
        idle = m_cur[6:1] == 6'd0;
        @(posedge clk);
        if (idle && start) begin
            m_nlat = nIn;
            exp_q.delete();
            if (nIn >= 4'd2) begin
                exp_q.push_back(V_INIT);
                repeat (neq_off ? 15 : int'(nIn) - 1) exp_q.push_back(V_RUN);
                if (neq_off) exp_q.push_back(V_DONE | 7'd1);
                else begin
                    exp_q.push_back(V_LAST);
                    exp_q.push_back(V_DONE);
                end
            end else exp_q.push_back(V_DONE | 7'd1);
        end else if (!idle && abort) exp_q.delete();
        m_cur = exp_q.size() != 0 ? exp_q.pop_front() : {6'd0, m_cur[0]};
        #1;
    endtask

    task automatic run_n(input string name, input logic [3:0] n, input int len,
                         output int steps, output int ens, output int done_at, output logic first_err);
        steps = 0; ens = 0; done_at = 0; first_err = 1'bx;
        start = 1'b1; nIn = n;
        for (int i = 1; i <= len; i++) begin
            tick();
            start = 1'b0;
            vectors++;
            if (obs !== m_cur) begin
                miscompares++;
                $display("FAIL %s ctrl cyc=%0d act=%b req=%b", name, i, obs, m_cur);
            end
            vectors++;
            if (nLat !== m_nlat) begin
                miscompares++;
                $display("FAIL %s nLat cyc=%0d act=%0d req=%0d", name, i, nLat, m_nlat);
            end
            steps += int'(stepEn);
            ens   += int'(enCount);
            if (done && done_at == 0) done_at = i;
            if (i == 1) first_err = err;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; nIn = '0;
        #3;
        vectors++;
        if (obs !== 7'd0 || nLat !== 4'd0) begin
            miscompares++;
            $display("FAIL reset act=%b/%0d req=0000000/0", obs, nLat);
        end
        @(negedge clk) rst = 1'b0;
        m_cur = '0; m_nlat = '0; exp_q.delete();
    endtask

    task automatic test_run(input string name, input logic [3:0] n, input int exp_steps,
                            input int exp_ens, input int exp_done, input logic exp_err);
        int s, e, d;
        logic fe;
        run_n(name, n, exp_done + 3, s, e, d, fe);
        vectors++;
        if (s !== exp_steps || e !== exp_ens || d !== exp_done) begin
            miscompares++;
            $display("FAIL %s timing steps/en/done act=%0d/%0d/%0d req=%0d/%0d/%0d",
                     name, s, e, d, exp_steps, exp_ens, exp_done);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL %s err act=%b req=%b", name, err, exp_err);
        end
    endtask

    task automatic test_illegal();
        int s, e, d;
        logic fe;
        test_run("n1", 4'd1, 0, 0, 1, 1'b1);
        test_run("n0", 4'd0, 0, 0, 1, 1'b1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky act=%b req=1", err);
        end
        run_n("n3", 4'd3, 8, s, e, d, fe);
        vectors++;
        if (fe !== 1'b0 || s !== 3 || d !== 5) begin
            miscompares++;
            $display("FAIL err_clear init_err/steps/done act=%b/%0d/%0d req=0/3/5", fe, s, d);
        end
    endtask

    task automatic test_wdog();
        neq_off = 1'b1;
        test_run("wdog", 4'd5, 15, 15, 17, 1'b1);
        neq_off = 1'b0;
        test_run("n15", 4'd15, 15, 14, 17, 1'b0);
    endtask

    task automatic test_abort();
        start = 1'b1; nIn = 4'd6;
        for (int i = 1; i <= 10; i++) begin
            tick();
            start = 1'b0;
            abort = i == 3;
            if (i == 4) begin
                vectors++;
                if (obs !== 7'd0 || nLat !== 4'd6) begin
                    miscompares++;
                    $display("FAIL abort act=%b/%0d req=0000000/6", obs, nLat);
                end
            end
            vectors++;
            if (obs !== m_cur) begin
                miscompares++;
                $display("FAIL abort ctrl cyc=%0d act=%b req=%b", i, obs, m_cur);
            end
        end
    endtask

    task automatic test_rst_last();
        start = 1'b1; nIn = 4'd4;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start = 1'b0;
        end
        vectors++;
        if (obs !== V_LAST) begin
            miscompares++;
            $display("FAIL rst_pre act=%b req=%b", obs, V_LAST);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 7'd0 || nLat !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_last act=%b/%0d req=0000000/0", obs, nLat);
        end
        #1 rst = 1'b0;
        m_cur = '0; m_nlat = '0; exp_q.delete();
        tick();
        vectors++;
        if (obs !== 7'd0) begin
            miscompares++;
            $display("FAIL rst_after act=%b req=0000000", obs);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; nIn = 4'd9;
        for (int i = 1; i <= 16; i++) begin
            tick();
            start = (i >= 3 && i <= 5) || i == 11;
            nIn   = i == 11 ? 4'd5 : 4'd3;
            vectors++;
            if (obs !== m_cur || nLat !== m_nlat) begin
                miscompares++;
                $display("FAIL b2b cyc=%0d act=%b/%0d req=%b/%0d", i, obs, nLat, m_cur, m_nlat);
            end
        end
        vectors++;
        if (nLat !== 4'd9) begin
            miscompares++;
            $display("FAIL b2b_nlat act=%0d req=9", nLat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start = $urandom_range(0, 3) == 0;
            abort = $urandom_range(0, 19) == 0;
            nIn   = 4'($urandom);
            noise = 1'($urandom);
            tick();
            vectors++;
            if (obs !== m_cur || nLat !== m_nlat) begin
                miscompares++;
                $display("FAIL random cyc=%0d act=%b/%0d req=%b/%0d", i, obs, nLat, m_cur, m_nlat);
            end
        end
        start = 1'b0; abort = 1'b0; noise = 1'b0;
        repeat (20) tick();
        vectors++;
        if (obs !== m_cur || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain act=%b req=%b", obs, m_cur);
        end
    endtask

    initial begin
        test_reset();
        test_run("n4", 4'd4, 4, 3, 6, 1'b0);
        test_run("n2", 4'd2, 2, 1, 4, 1'b0);
        test_illegal();
        test_wdog();
        test_abort();
        test_rst_last();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
